// File: rtl/territory_ranker.sv
// Counts each player's cells in the territory RAM after the match ends, then ranks
// the four players by territory size (stable, descending) for the podium display.
module territory_ranker #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int RD_LAT = 2,
   parameter logic [2:0] P1_COL = 3'b001,
   parameter logic [2:0] P2_COL = 3'b010,
   parameter logic [2:0] P3_COL = 3'b100,
   parameter logic [2:0] P4_COL = 3'b110
) (
   input  logic        CLOCK_50,
   input  logic        resetn,
   input  logic        start,
   output logic [14:0] ram_address,
   input  logic [2:0]  ram_q,
   output logic [14:0] p1_count,
   output logic [14:0] p2_count,
   output logic [14:0] p3_count,
   output logic [14:0] p4_count,
   output logic [11:0] ordered_colours,
   output logic        done_ordering,
   output logic        busy
);

   // The address register is one of the RD_LAT stages, so the valid pipe is one shorter.
   localparam int VD = RD_LAT - 1;

   typedef enum logic [2:0] {IDLE, SCAN, DRAIN, SORT, DONE} state_t;

   state_t      state;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [VD-1:0] vld_p;
   logic [3:0]  drain_cnt;
   logic [2:0]  step;
   logic [1:0]  pair;
   logic [1:0]  pair_hi;
   logic        last_cell;
   logic        accept;
   logic        hit;

   logic [14:0] slot_cnt [4];
   logic [2:0]  slot_col [4];
   logic [14:0] src_cnt  [4];
   logic [2:0]  src_col  [4];
   logic [14:0] nxt_cnt  [4];
   logic [2:0]  nxt_col  [4];

   assign ram_address = {x, y};
   assign last_cell   = (x == 8'(SCREEN_W - 1)) && (y == 7'(SCREEN_H - 1));
   assign accept      = start && (state == IDLE || state == DONE);
   assign hit         = vld_p[VD-1];

   // One compare-swap of the odd bubble network; step 0 reads the live counters directly.
   always_comb begin
      src_cnt[0] = p1_count;  src_col[0] = P1_COL;
      src_cnt[1] = p2_count;  src_col[1] = P2_COL;
      src_cnt[2] = p3_count;  src_col[2] = P3_COL;
      src_cnt[3] = p4_count;  src_col[3] = P4_COL;
      if (step != 3'd0) begin
         for (int i = 0; i < 4; i++) begin
            src_cnt[i] = slot_cnt[i];
            src_col[i] = slot_col[i];
         end
      end
      case (step)
         3'd1, 3'd4: pair = 2'd1;
         3'd2:       pair = 2'd2;
         default:    pair = 2'd0;
      endcase
      pair_hi = pair + 2'd1;
      for (int i = 0; i < 4; i++) begin
         nxt_cnt[i] = src_cnt[i];
         nxt_col[i] = src_col[i];
      end
      if (src_cnt[pair_hi] > src_cnt[pair]) begin
         nxt_cnt[pair]    = src_cnt[pair_hi];
         nxt_col[pair]    = src_col[pair_hi];
         nxt_cnt[pair_hi] = src_cnt[pair];
         nxt_col[pair_hi] = src_col[pair];
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (state == SORT) begin
         for (int i = 0; i < 4; i++) begin
            slot_cnt[i] <= nxt_cnt[i];
            slot_col[i] <= nxt_col[i];
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         p1_count <= '0;
         p2_count <= '0;
         p3_count <= '0;
         p4_count <= '0;
      end else if (accept) begin
         p1_count <= '0;
         p2_count <= '0;
         p3_count <= '0;
         p4_count <= '0;
      end else if (hit) begin
         if (ram_q == P1_COL) p1_count <= p1_count + 15'd1;
         if (ram_q == P2_COL) p2_count <= p2_count + 15'd1;
         if (ram_q == P3_COL) p3_count <= p3_count + 15'd1;
         if (ram_q == P4_COL) p4_count <= p4_count + 15'd1;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state           <= IDLE;
         x               <= '0;
         y               <= '0;
         vld_p           <= '0;
         drain_cnt       <= '0;
         step            <= '0;
         ordered_colours <= {P1_COL, P2_COL, P3_COL, P4_COL};
         done_ordering   <= 1'b0;
         busy            <= 1'b0;
      end else begin
         vld_p <= VD'({vld_p, state == SCAN});
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  x             <= '0;
                  y             <= '0;
                  vld_p         <= '0;
                  done_ordering <= 1'b0;
                  busy          <= 1'b1;
                  state         <= SCAN;
               end
            end
            SCAN: begin
               if (last_cell) begin
                  drain_cnt <= '0;
                  state     <= DRAIN;
               end else if (y == 7'(SCREEN_H - 1)) begin
                  x <= x + 8'd1;
                  y <= '0;
               end else begin
                  y <= y + 7'd1;
               end
            end
            DRAIN: begin
               if (drain_cnt == 4'(RD_LAT - 1)) begin
                  step  <= '0;
                  state <= SORT;
               end else begin
                  drain_cnt <= drain_cnt + 4'd1;
               end
            end
            SORT: begin
               step <= step + 3'd1;
               if (step == 3'd5) begin
                  ordered_colours <= {nxt_col[0], nxt_col[1], nxt_col[2], nxt_col[3]};
                  done_ordering   <= 1'b1;
                  busy            <= 1'b0;
                  state           <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_territory_ranker.sv
// Bench for territory_ranker: a registered RAM model feeds the scanner, and a scoreboard
// of model-derived counts and rankings is compared when done_ordering rises.
module tb_territory_ranker;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [14:0] ram_address;
   logic [2:0]  ram_q;
   logic [14:0] p1_count, p2_count, p3_count, p4_count;
   logic [11:0] ordered_colours;
   logic        done_ordering;
   logic        busy;

   logic [2:0]  mem [0:32767];
   logic [14:0] ram_addr_reg = '0;

   typedef struct packed {
      logic [14:0] c1;
      logic [14:0] c2;
      logic [14:0] c3;
      logic [14:0] c4;
      logic [11:0] col;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   always #10 clk = ~clk;

   always @(posedge clk) ram_addr_reg <= ram_address;
   assign ram_q = mem[ram_addr_reg];

   territory_ranker dut (
      .CLOCK_50(clk),
      .resetn(resetn),
      .start(start),
      .ram_address(ram_address),
      .ram_q(ram_q),
      .p1_count(p1_count),
      .p2_count(p2_count),
      .p3_count(p3_count),
      .p4_count(p4_count),
      .ordered_colours(ordered_colours),
      .done_ordering(done_ordering),
      .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
      end
   endtask

   function automatic logic [14:0] exp_addr(input int n);
      return 15'(((n / 120) << 7) | (n % 120));
   endfunction

   // Counts owned cells in the visible area and places each player by how many beat it.
   function automatic exp_t model();
      exp_t        e;
      int          c [4];
      logic [2:0]  colr [4];
      logic [11:0] col;
      logic [2:0]  v;
      int          rank;
      colr[0] = 3'b001; colr[1] = 3'b010; colr[2] = 3'b100; colr[3] = 3'b110;
      for (int p = 0; p < 4; p++) c[p] = 0;
      for (int xi = 0; xi < 160; xi++) begin
         for (int yi = 0; yi < 120; yi++) begin
            v = mem[{xi[7:0], yi[6:0]}];
            for (int p = 0; p < 4; p++) if (v == colr[p]) c[p]++;
         end
      end
      col = '0;
      for (int p = 0; p < 4; p++) begin
         rank = 0;
         for (int q = 0; q < 4; q++)
            if (c[q] > c[p] || (c[q] == c[p] && q < p)) rank++;
         col[11 - 3*rank -: 3] = colr[p];
      end
      e.c1 = 15'(c[0]); e.c2 = 15'(c[1]); e.c3 = 15'(c[2]); e.c4 = 15'(c[3]);
      e.col = col;
      return e;
   endfunction

   task automatic fill(input int mode);
      int t;
      for (int a = 0; a < 32768; a++) mem[a] = 3'b000;
      if (mode == 1) begin
         for (t = 0; t < 210; t++) begin
            if (t < 100)      mem[{8'(t / 119), 7'(t % 119)}] = 3'b100;
            else if (t < 150) mem[{8'(t / 119), 7'(t % 119)}] = 3'b001;
            else if (t < 200) mem[{8'(t / 119), 7'(t % 119)}] = 3'b010;
            else              mem[{8'(t / 119), 7'(t % 119)}] = 3'b110;
         end
         for (int xi = 0; xi < 160; xi++) mem[{xi[7:0], 7'd119}] = 3'b111;
         // Cells outside the visible area must never be counted.
         for (int xi = 0; xi < 256; xi++)
            for (int yi = 120; yi < 128; yi++) mem[{xi[7:0], yi[6:0]}] = 3'b001;
         for (int xi = 160; xi < 256; xi++)
            for (int yi = 0; yi < 120; yi++) mem[{xi[7:0], yi[6:0]}] = 3'b001;
      end else if (mode == 2) begin
         for (int xi = 0; xi < 160; xi++)
            for (int yi = 0; yi < 120; yi++) mem[{xi[7:0], yi[6:0]}] = 3'b110;
      end
   endtask

   task automatic check_reset_values(input string pfx);
      chk({pfx, "_addr"}, 32'(ram_address), 32'h0);
      chk({pfx, "_p1"}, 32'(p1_count), 32'h0);
      chk({pfx, "_p2"}, 32'(p2_count), 32'h0);
      chk({pfx, "_p3"}, 32'(p3_count), 32'h0);
      chk({pfx, "_p4"}, 32'(p4_count), 32'h0);
      chk({pfx, "_order"}, 32'(ordered_colours), 32'(12'b001_010_100_110));
      chk({pfx, "_done"}, 32'(done_ordering), 32'h0);
      chk({pfx, "_busy"}, 32'(busy), 32'h0);
   endtask

   task automatic run_scan(input bit mid_pulse, input int abort_at, input logic [11:0] known_col);
      exp_t e;
      bit   got;
      int   lat;
      int   errs;
      if (abort_at < 0) sb.push_back(model());
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      errs = 0;
      got = 1'b0;
      lat = -1;
      for (int n = 0; n < 19300; n++) begin
         @(negedge clk);
         if (n == 0) begin
            chk("start_done_low", 32'(done_ordering), 32'h0);
            chk("start_busy", 32'(busy), 32'h1);
            chk("start_cnt_clear", 32'(p1_count | p2_count | p3_count | p4_count), 32'h0);
         end
         if (n == abort_at) begin
            resetn = 1'b0;
            #1;
            check_reset_values("abort");
            @(negedge clk);
            resetn = 1'b1;
            return;
         end
         if (n < 19200 && ram_address !== exp_addr(n)) errs++;
         if (mid_pulse) start = (n == 500);
         if (done_ordering) begin
            got = 1'b1;
            lat = n;
            break;
         end
      end
      start = 1'b0;
      chk("addr_seq_errs", 32'(errs), 32'h0);
      chk("latency", got ? 32'(lat) : 32'hFFFF_FFFF, 32'd19208);
      if (sb.size() == 0) begin
         chk("sb_nonempty", 32'h0, 32'h1);
      end else begin
         e = sb.pop_front();
         chk("p1_count", 32'(p1_count), 32'(e.c1));
         chk("p2_count", 32'(p2_count), 32'(e.c2));
         chk("p3_count", 32'(p3_count), 32'(e.c3));
         chk("p4_count", 32'(p4_count), 32'(e.c4));
         chk("ordered", 32'(ordered_colours), 32'(e.col));
      end
      chk("ordered_known", 32'(ordered_colours), 32'(known_col));
      chk("done_busy_low", 32'(busy), 32'h0);
   endtask

   initial begin
      fill(0);
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("rst");
      resetn = 1'b1;
      @(negedge clk);

      // Empty board, started from IDLE.
      run_scan(1'b0, -1, 12'b001_010_100_110);

      // New contents loaded while in DONE, then re-run.
      fill(1);
      run_scan(1'b0, -1, 12'b100_001_010_110);

      // Board all P4; abort mid-scan, then a full scan with a stray start pulse.
      fill(2);
      run_scan(1'b0, 9000, 12'b0);
      run_scan(1'b1, -1, 12'b110_001_010_100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
